// File: rtl/clock_div_prog.sv
// Programmable multi-channel clock divider. Each channel runs a 0..D-1 counter
// and produces a registered divided clock and a period-start tick.
module clock_div_prog #(
  parameter int CH      = 4,
  parameter int W       = 8,
  parameter int DEF_DIV = 2
) (
  input  logic                                 clk_in,
  input  logic                                 rst_x,
  input  logic [CH-1:0]                        ch_en,
  input  logic                                 sync_all,
  input  logic                                 cfg_vld,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] cfg_ch,
  input  logic [W-1:0]                         cfg_div,
  output logic                                 cfg_rdy,
  output logic [CH-1:0]                        clk_out,
  output logic [CH-1:0]                        tick
);

  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [W-1:0] DEF_D = (DEF_DIV < 2) ? W'(1) : W'(DEF_DIV);

  logic [W-1:0]  cnt     [CH];
  logic [W-1:0]  d_act   [CH];
  logic [W-1:0]  d_pend  [CH];
  logic [CH-1:0] pend;
  logic [CH-1:0] run;

  logic [W-1:0]  cnt_n    [CH];
  logic [W-1:0]  d_act_n  [CH];
  logic [W-1:0]  d_pend_n [CH];
  logic [CH-1:0] pend_n;
  logic [CH-1:0] clk_n;
  logic [CH-1:0] tick_n;
  logic [CH-1:0] acc;
  logic [CH-1:0] bnd;
  logic [W-1:0]  div_norm;

  assign div_norm = (cfg_div < W'(2)) ? W'(1) : cfg_div;

  // Channel numbers outside 0..CH-1 never match, so they leave cfg_rdy low.
  always_comb begin
    cfg_rdy = 1'b0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (cfg_ch == CW'(i)) cfg_rdy = ~pend[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      acc[i]      = cfg_vld & cfg_rdy & (cfg_ch == CW'(i));
      // Period boundary: first enabled cycle, global sync, or counter wrap.
      bnd[i]      = ~run[i] | sync_all | (cnt[i] == d_act[i] - W'(1));
      cnt_n[i]    = '0;
      d_act_n[i]  = d_act[i];
      d_pend_n[i] = d_pend[i];
      pend_n[i]   = pend[i];
      if (ch_en[i]) begin
        if (bnd[i]) begin
          pend_n[i] = 1'b0;
          if (acc[i])       d_act_n[i] = div_norm;
          else if (pend[i]) d_act_n[i] = d_pend[i];
        end else begin
          cnt_n[i] = cnt[i] + W'(1);
          if (acc[i]) begin
            pend_n[i]   = 1'b1;
            d_pend_n[i] = div_norm;
          end
        end
      end else begin
        if (pend[i]) begin
          d_act_n[i] = d_pend[i];
          pend_n[i]  = 1'b0;
        end
        if (acc[i]) begin
          pend_n[i]   = 1'b1;
          d_pend_n[i] = div_norm;
        end
      end
      tick_n[i] = ch_en[i] & bnd[i];
      clk_n[i]  = ch_en[i] & ((d_act_n[i] == W'(1)) | (cnt_n[i] < (d_act_n[i] >> 1)));
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_x) begin
      for (int unsigned i = 0; i < CH; i++) begin
        cnt[i]    <= '0;
        d_act[i]  <= DEF_D;
        d_pend[i] <= '0;
      end
      pend    <= '0;
      run     <= '0;
      clk_out <= '0;
      tick    <= '0;
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        cnt[i]    <= cnt_n[i];
        d_act[i]  <= d_act_n[i];
        d_pend[i] <= d_pend_n[i];
      end
      pend    <= pend_n;
      run     <= ch_en;
      clk_out <= clk_n;
      tick    <= tick_n;
    end
  end

endmodule

// File: tb/tb_clock_div_prog.sv
// Bench for clock_div_prog: directed vector table plus randomized traffic
// compared against a period/phase reference model.
module tb_clock_div_prog;
  localparam int CH      = 4;
  localparam int W       = 8;
  localparam int DEF_DIV = 2;
  localparam int CW      = 2;

  logic          clk_in = 1'b0;
  logic          rst_x = 1'b0;
  logic [CH-1:0] ch_en = '0;
  logic          sync_all = 1'b0;
  logic          cfg_vld = 1'b0;
  logic [CW-1:0] cfg_ch = '0;
  logic [W-1:0]  cfg_div = '0;
  logic          cfg_rdy;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] tick;

  always #5 clk_in = ~clk_in;

  clock_div_prog #(.CH(CH), .W(W), .DEF_DIV(DEF_DIV)) dut (
    .clk_in  (clk_in),
    .rst_x   (rst_x),
    .ch_en   (ch_en),
    .sync_all(sync_all),
    .cfg_vld (cfg_vld),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .cfg_rdy (cfg_rdy),
    .clk_out (clk_out),
    .tick    (tick)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per channel, whether it runs, cycles since period start,
  // current period length and a queued next period (0 = none queued).
  int m_on  [CH];
  int m_age [CH];
  int m_per [CH];
  int m_nxt [CH];

  typedef struct {
    logic          rst;
    logic [CH-1:0] en;
    logic          sync;
    logic          vld;
    logic [CW-1:0] ch;
    logic [W-1:0]  div;
    logic [CH-1:0] eclk;
    logic [CH-1:0] etick;
    logic          erdy;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [CH-1:0] m_clk();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++)
      r[i] = (m_on[i] != 0) && (m_per[i] == 1 || m_age[i] < m_per[i] / 2);
    return r;
  endfunction

  function automatic logic [CH-1:0] m_tick();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = (m_on[i] != 0) && (m_age[i] == 0);
    return r;
  endfunction

  function automatic logic m_rdy();
    return (int'(cfg_ch) < CH) && (m_nxt[cfg_ch] == 0);
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int acc_ch;
    int v;
    acc_ch = -1;
    if (cfg_vld && m_rdy()) acc_ch = int'(cfg_ch);
    v = (cfg_div < 2) ? 1 : int'(cfg_div);
    for (int i = 0; i < CH; i++) begin
      if (!rst_x) begin
        m_on[i] = 0; m_age[i] = 0; m_per[i] = DEF_DIV; m_nxt[i] = 0;
      end else if (ch_en[i]) begin
        if (m_on[i] == 0 || sync_all || m_age[i] == m_per[i] - 1) begin
          if (acc_ch == i)       m_per[i] = v;
          else if (m_nxt[i] != 0) m_per[i] = m_nxt[i];
          m_nxt[i] = 0;
          m_age[i] = 0;
        end else begin
          m_age[i]++;
          if (acc_ch == i) m_nxt[i] = v;
        end
        m_on[i] = 1;
      end else begin
        m_on[i]  = 0;
        m_age[i] = 0;
        if (m_nxt[i] != 0) begin m_per[i] = m_nxt[i]; m_nxt[i] = 0; end
        if (acc_ch == i) m_nxt[i] = v;
      end
    end
  endtask

  task automatic run_cycle(input logic r, input logic [CH-1:0] en, input logic s,
                           input logic vl, input logic [CW-1:0] ch, input logic [W-1:0] dv);
    rst_x = r; ch_en = en; sync_all = s; cfg_vld = vl; cfg_ch = ch; cfg_div = dv;
    model_step();
    @(posedge clk_in);
    @(negedge clk_in);
    check("model_clk_out", 32'(clk_out), 32'(m_clk()));
    check("model_tick", 32'(tick), 32'(m_tick()));
    check("model_cfg_rdy", 32'(cfg_rdy), 32'(m_rdy()));
  endtask

  function automatic void add(input logic r, input logic [CH-1:0] en, input logic s,
                              input logic vl, input logic [CW-1:0] ch, input logic [W-1:0] dv,
                              input logic [CH-1:0] ec, input logic [CH-1:0] et, input logic er);
    vec_t x;
    x.rst = r; x.en = en; x.sync = s; x.vld = vl; x.ch = ch; x.div = dv;
    x.eclk = ec; x.etick = et; x.erdy = er;
    tbl.push_back(x);
  endfunction

  initial begin
    // reset, then ch0 at default factor 2
    add(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 1);
    add(1, 4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0001, 1);
    add(1, 4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 1);
    add(1, 4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0001, 1);
    add(1, 4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 1);
    // D=0 and D=1 on ch0: held high, tick every cycle
    add(1, 4'b0001, 0, 1, 0, 0, 4'b0001, 4'b0001, 1);
    add(1, 4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0001, 1);
    add(1, 4'b0001, 0, 1, 0, 1, 4'b0001, 4'b0001, 1);
    // ch1 starts at 2, D=5 written mid-period
    add(1, 4'b0011, 0, 0, 0, 0, 4'b0011, 4'b0011, 1);
    add(1, 4'b0011, 0, 1, 1, 5, 4'b0001, 4'b0001, 0);
    add(1, 4'b0011, 0, 0, 1, 0, 4'b0011, 4'b0011, 1);
    add(1, 4'b0011, 0, 0, 1, 0, 4'b0011, 4'b0001, 1);
    add(1, 4'b0011, 0, 0, 1, 0, 4'b0001, 4'b0001, 1);
    add(1, 4'b0011, 0, 0, 1, 0, 4'b0001, 4'b0001, 1);
    add(1, 4'b0011, 0, 0, 1, 0, 4'b0001, 4'b0001, 1);
    add(1, 4'b0011, 0, 0, 1, 0, 4'b0011, 4'b0011, 1);
    // second write while pending is refused; first value (3) takes effect
    add(1, 4'b0011, 0, 1, 1, 3, 4'b0011, 4'b0001, 0);
    add(1, 4'b0011, 0, 1, 1, 7, 4'b0001, 4'b0001, 0);
    add(1, 4'b0011, 0, 0, 1, 0, 4'b0001, 4'b0001, 0);
    add(1, 4'b0011, 0, 0, 1, 0, 4'b0001, 4'b0001, 0);
    add(1, 4'b0011, 0, 0, 1, 0, 4'b0011, 4'b0011, 1);
    add(1, 4'b0011, 0, 0, 1, 0, 4'b0001, 4'b0001, 1);
    add(1, 4'b0011, 0, 0, 1, 0, 4'b0001, 4'b0001, 1);
    add(1, 4'b0011, 0, 0, 1, 0, 4'b0011, 4'b0011, 1);
    // pending write on ch2 killed by reset; ch2 then runs at 2
    add(1, 4'b0011, 0, 1, 2, 9, 4'b0001, 4'b0001, 0);
    add(0, 4'b0000, 0, 0, 2, 0, 4'b0000, 4'b0000, 1);
    add(1, 4'b0100, 0, 0, 2, 0, 4'b0100, 4'b0100, 1);
    add(1, 4'b0100, 0, 0, 2, 0, 4'b0000, 4'b0000, 1);
    add(1, 4'b0100, 0, 0, 2, 0, 4'b0100, 4'b0100, 1);
    // ch0 D=4, ch1 D=6, then sync_all aligns them
    add(1, 4'b0011, 0, 1, 0, 4, 4'b0011, 4'b0011, 1);
    add(1, 4'b0011, 0, 1, 1, 6, 4'b0001, 4'b0000, 0);
    add(1, 4'b0011, 0, 0, 1, 0, 4'b0010, 4'b0010, 1);
    add(1, 4'b0011, 0, 0, 1, 0, 4'b0010, 4'b0000, 1);
    add(1, 4'b0011, 0, 0, 1, 0, 4'b0011, 4'b0001, 1);
    add(1, 4'b0011, 1, 0, 1, 0, 4'b0011, 4'b0011, 1);
    add(1, 4'b0011, 0, 0, 1, 0, 4'b0011, 4'b0000, 1);
    add(1, 4'b0011, 0, 0, 1, 0, 4'b0010, 4'b0000, 1);
    add(1, 4'b0011, 0, 0, 1, 0, 4'b0000, 4'b0000, 1);
    add(1, 4'b0011, 0, 0, 1, 0, 4'b0001, 4'b0001, 1);

    @(negedge clk_in);
    for (int k = 0; k < tbl.size(); k++) begin
      run_cycle(tbl[k].rst, tbl[k].en, tbl[k].sync, tbl[k].vld, tbl[k].ch, tbl[k].div);
      check($sformatf("vec%0d_clk_out", k), 32'(clk_out), 32'(tbl[k].eclk));
      check($sformatf("vec%0d_tick", k), 32'(tick), 32'(tbl[k].etick));
      check($sformatf("vec%0d_cfg_rdy", k), 32'(cfg_rdy), 32'(tbl[k].erdy));
    end

    begin
      logic [CH-1:0] en_r;
      en_r = 4'b1111;
      for (int k = 0; k < 3000; k++) begin
        if ($urandom_range(0, 19) == 0) en_r = CH'($urandom);
        run_cycle($urandom_range(0, 99) != 0, en_r, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 1) == 1, CW'($urandom), W'($urandom_range(0, 12)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
